uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART. It oversamples the serial input at 16x baud, frames start, data, parity and stop bits, and assembles the receive shift register. It drives the existing `parity_checker` with the assembled word, then presents data plus error flags to the register interface under a valid/ack handshake. It sits between the baud generator and the receive holding register logic.

---
 rtl/uart_rx_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - 16x oversampling UART receive sequencer with parity checker
module parity_checker (
    input  logic [7:0] data,
    input  logic       par_bit,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    output logic       parity_error
);
    logic ones_odd;

    always_comb begin
        ones_odd     = (^data) ^ par_bit;
        parity_error = 1'b0;
        if (pen) begin
            // Stick parity forces the bit to the inverse of eps.
            if (sp)
                parity_error = (par_bit == eps);
            else if (eps)
                parity_error = ones_odd;
            else
                parity_error = ~ones_odd;
        end
    end
endmodule

module uart_rx_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rxd,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    input  logic [1:0] wls,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       break_detect,
    output logic       overrun_error,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    rxd_s;
    logic [3:0]              tick_cnt;
    logic [2:0]              bit_cnt;
    logic [7:0]              rsr;
    logic                    rcv_par;
    logic                    any_one;
    logic                    l_pen;
    logic                    l_eps;
    logic                    l_sp;
    logic [1:0]              l_wls;
    logic                    par_err_c;
    logic                    frame_done;

    assign rxd_s      = sync_q[SYNC_STAGES-1];
    assign frame_done = baud_tick && (state == STOP) && (tick_cnt == 4'd15);

    parity_checker u_parity_checker (
        .data         (rsr),
        .par_bit      (rcv_par),
        .pen          (l_pen),
        .eps          (l_eps),
        .sp           (l_sp),
        .parity_error (par_err_c)
    );

    always_ff @(posedge clk) begin
        if (rst)
            sync_q <= '1;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tick_cnt      <= 4'd0;
            bit_cnt       <= 3'd0;
            rsr           <= 8'd0;
            rcv_par       <= 1'b0;
            any_one       <= 1'b0;
            l_pen         <= 1'b0;
            l_eps         <= 1'b0;
            l_sp          <= 1'b0;
            l_wls         <= 2'd0;
            busy          <= 1'b0;
            rx_data       <= 8'd0;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            break_detect  <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        l_pen   <= pen;
                        l_eps   <= eps;
                        l_sp    <= sp;
                        l_wls   <= wls;
                        rsr     <= 8'd0;
                        rcv_par <= 1'b0;
                        any_one <= 1'b0;
                        if (!rxd_s) begin
                            state    <= START;
                            tick_cnt <= 4'd0;
                            busy     <= 1'b1;
                        end
                    end
                    START: begin
                        // The detect tick is tick 0, so the 7th following tick is mid start bit.
                        if (tick_cnt == 4'd6) begin
                            if (rxd_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= 4'd0;
                                bit_cnt  <= 3'd0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            rsr[bit_cnt] <= rxd_s;
                            any_one      <= any_one | rxd_s;
                            if (bit_cnt == ({1'b0, l_wls} + 3'd4))
                                state <= l_pen ? PARITY : STOP;
                            else
                                bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            rcv_par <= rxd_s;
                            any_one <= any_one | rxd_s;
                            state   <= STOP;
                        end
                    end
                    STOP: begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end

            if (frame_done) begin
                if (!rx_valid || rx_ack) begin
                    rx_data       <= rsr;
                    parity_error  <= par_err_c;
                    framing_error <= ~rxd_s;
                    break_detect  <= ~any_one & ~rxd_s;
                    overrun_error <= 1'b0;
                    rx_valid      <= 1'b1;
                end else begin
                    overrun_error <= 1'b1;
                end
            end else if (rx_ack && rx_valid) begin
                rx_valid      <= 1'b0;
                parity_error  <= 1'b0;
                framing_error <= 1'b0;
                break_detect  <= 1'b0;
                overrun_error <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic       rxd;
    logic       pen;
    logic       eps;
    logic       sp;
    logic [1:0] wls;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_error;
    logic       framing_error;
    logic       break_detect;
    logic       overrun_error;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_rx_ctrl #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_tick     (baud_tick),
        .rxd           (rxd),
        .pen           (pen),
        .eps           (eps),
        .sp            (sp),
        .wls           (wls),
        .rx_ack        (rx_ack),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .break_detect  (break_detect),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Three quiet cycles, then a one-cycle tick; rx_ack optionally rides on the tick edge.
    task automatic tick_ack(input logic ack);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        baud_tick = 1'b1;
        rx_ack    = ack;
        @(posedge clk);
        #1;
        baud_tick = 1'b0;
        rx_ack    = 1'b0;
    endtask

    task automatic tick();
        tick_ack(1'b0);
    endtask

    task automatic drive(input logic v, input int n);
        rxd = v;
        repeat (n) tick();
    endtask

    task automatic idle(input int n);
        drive(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                              input logic par_bit, input logic stop_bit, input int stop_ticks);
        drive(1'b0, 16);
        for (int i = 0; i < nbits; i++) drive(d[i], 16);
        if (par_en) drive(par_bit, 16);
        drive(stop_bit, stop_ticks);
        rxd = 1'b1;
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    logic [7:0] b5a;

    initial begin
        rst = 1'b1; baud_tick = 1'b0; rxd = 1'b1; rx_ack = 1'b0;
        pen = 1'b0; eps = 1'b0; sp = 1'b0; wls = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {parity_error, framing_error, break_detect, overrun_error}, 0);
        idle(4);

        // 8N1 0xA5, stop sampled at +151
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 7);
        check("8n1_pre_valid", rx_valid, 0);
        check("8n1_pre_busy", busy, 1);
        tick();
        check("8n1_valid", rx_valid, 1);
        check("8n1_busy", busy, 0);
        check("8n1_data", rx_data, 8'hA5);
        check("8n1_flags", {parity_error, framing_error, break_detect, overrun_error}, 0);
        ack();
        check("8n1_ack_valid", rx_valid, 0);
        check("8n1_ack_data", rx_data, 8'hA5);
        idle(4);

        // 7E1 0x35 has four ones: even parity bit is 0
        wls = 2'd2; pen = 1'b1; eps = 1'b1;
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 8);
        check("7e1_bad_data", rx_data, 8'h35);
        check("7e1_bad_pe", parity_error, 1);
        ack();
        idle(4);
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 8);
        check("7e1_ok_valid", rx_valid, 1);
        check("7e1_ok_pe", parity_error, 0);
        ack();
        idle(4);

        // 5N1 framing error, then break
        wls = 2'd0; pen = 1'b0; eps = 1'b0;
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0, 8);
        check("5n1_fe_data", rx_data, 8'h1F);
        check("5n1_fe", framing_error, 1);
        check("5n1_fe_bd", break_detect, 0);
        ack();
        idle(4);
        send_frame(8'h00, 5, 1'b0, 1'b0, 1'b0, 8);
        check("brk_bd", break_detect, 1);
        check("brk_data", rx_data, 8'h00);
        check("brk_fe", framing_error, 1);
        ack();
        check("brk_ack_flags", {parity_error, framing_error, break_detect, overrun_error}, 0);
        idle(4);

        // Overrun without ack
        wls = 2'd3;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 8);
        idle(4);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 8);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_oe", overrun_error, 1);
        check("ovr_valid", rx_valid, 1);
        ack();
        check("ovr_ack_valid", rx_valid, 0);
        check("ovr_ack_oe", overrun_error, 0);
        idle(4);

        // Ack on the completion edge of the second frame
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 8);
        idle(4);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 7);
        tick_ack(1'b1);
        check("ackc_data", rx_data, 8'h22);
        check("ackc_valid", rx_valid, 1);
        check("ackc_oe", overrun_error, 0);
        ack();
        idle(4);

        // Four-tick low glitch
        rxd = 1'b0;
        repeat (3) tick();
        check("glitch_busy_hi", busy, 1);
        tick();
        idle(8);
        check("glitch_busy_lo", busy, 0);
        check("glitch_valid", rx_valid, 0);

        // Reset during data bit 3 with a held word present
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1, 8);
        check("pre_rst_valid", rx_valid, 1);
        idle(4);
        b5a = 8'h5A;
        drive(1'b0, 16);
        for (int i = 0; i < 3; i++) drive(b5a[i], 16);
        drive(b5a[3], 8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rxd = 1'b1;
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_flags", {parity_error, framing_error, break_detect, overrun_error}, 0);
        idle(20);
        check("post_rst_idle_valid", rx_valid, 0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 8);
        check("post_rst_valid", rx_valid, 1);
        check("post_rst_data", rx_data, 8'h5A);
        check("post_rst_flags", {parity_error, framing_error, break_detect, overrun_error}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
